wb_arbiter: RTL and testbench

Writeback arbiter that owns the single register-file write port (write_reg / target_reg / write_rd_data).
- Merges in-order pipeline results with out-of-order results from long-latency units (load miss, divider).
- Long-latency results go through a small FIFO. A starvation counter guarantees they drain.
- Exports a pending-destination scoreboard that decode uses to stall on RAW/WAW hazards.

---
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: pipe results, long-latency FIFO, starvation stall, pending scoreboard
// Optional same-cycle lu bypass when the FIFO is empty: define WB_BYPASS_EN.
module wb_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_valid,
    input  logic [4:0]                    pipe_rd,
    input  logic [31:0]                   pipe_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [4:0]                    lu_rd,
    input  logic [31:0]                   lu_data,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_rd,
    output logic                          write_reg,
    output logic [4:0]                    target_reg,
    output logic [31:0]                   write_rd_data,
    output logic [31:0]                   pending_mask,
    output logic                          pipe_stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          we_q, we_d;
    logic [4:0]    tgt_q, tgt_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   pend_q, pend_d;
    logic          perr_q, perr_d;

    logic slot_busy, fifo_nonempty, enq, deq, bypass;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    assign lu_ready      = (count_q < (AW+1)'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign slot_busy     = pipe_valid && (pipe_rd != 5'd0) && !stall_q;
    assign head_rd       = fifo_rd_q[rd_ptr_q];
    assign head_data     = fifo_data_q[rd_ptr_q];
    // Entries are visible to dequeue only after their enqueue edge, so no pass-through.
    assign deq           = !slot_busy && fifo_nonempty;
`ifdef WB_BYPASS_EN
    assign bypass        = !slot_busy && !fifo_nonempty && lu_valid && lu_ready;
`else
    assign bypass        = 1'b0;
`endif
    assign enq           = lu_valid && lu_ready && !bypass;

    always_comb begin
        we_d     = 1'b0;
        tgt_d    = tgt_q;
        wdata_d  = wdata_q;
        pend_d   = pend_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = '0;
        stall_d  = 1'b0;
        perr_d   = perr_q || (pipe_valid && stall_q);

        if (slot_busy) begin
            we_d    = 1'b1;
            tgt_d   = pipe_rd;
            wdata_d = pipe_data;
        end else if (deq) begin
            if (head_rd != 5'd0) begin
                we_d          = 1'b1;
                tgt_d         = head_rd;
                wdata_d       = head_data;
                pend_d[head_rd] = 1'b0;
            end
        end else if (bypass) begin
            if (lu_rd != 5'd0) begin
                we_d          = 1'b1;
                tgt_d         = lu_rd;
                wdata_d       = lu_data;
                pend_d[lu_rd] = 1'b0;
            end
        end

        if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
        if (enq && !deq)      count_d = count_q + (AW+1)'(1);
        else if (!enq && deq) count_d = count_q - (AW+1)'(1);

        // A denied non-empty FIFO forces a one-cycle pipe stall after STARVE_LIMIT cycles.
        if (fifo_nonempty && !deq) begin
            starve_d = starve_q + SW'(1);
            stall_d  = (starve_q == SW'(STARVE_LIMIT - 1));
        end

        // New issue outranks a same-cycle retire of the same register.
        if (issue_valid && issue_rd != 5'd0) pend_d[issue_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            tgt_q    <= '0;
            wdata_q  <= '0;
            pend_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            tgt_q    <= tgt_d;
            wdata_q  <= wdata_d;
            pend_q   <= pend_d;
            perr_q   <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

    assign write_reg     = we_q;
    assign target_reg    = tgt_q;
    assign write_rd_data = wdata_q;
    assign pending_mask  = pend_q;
    assign pipe_stall    = stall_q;
    assign fifo_count    = count_q;
    assign proto_err     = perr_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter (default build)
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, lu_valid, issue_valid;
    logic [4:0]  pipe_rd, lu_rd, issue_rd;
    logic [31:0] pipe_data, lu_data;
    logic        lu_ready, write_reg, pipe_stall, proto_err;
    logic [4:0]  target_reg;
    logic [31:0] write_rd_data, pending_mask;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .write_reg(write_reg), .target_reg(target_reg), .write_rd_data(write_rd_data),
        .pending_mask(pending_mask), .pipe_stall(pipe_stall),
        .fifo_count(fifo_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lu_valid = 0; lu_rd = 0; lu_data = 0;
        issue_valid = 0; issue_rd = 0;

        // 1: reset
        tick(); tick();
        rst = 1'b1;
        chk("rst_we", write_reg, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_ready", lu_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_perr", proto_err, 0);
        chk("rst_stall", pipe_stall, 0);

        // 2: single pipe write
        pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
        tick();
        pipe_valid = 0;
        chk("p_we", write_reg, 1);
        chk("p_tgt", target_reg, 5);
        chk("p_data", write_rd_data, 32'hDEADBEEF);
        tick();
        chk("p_we_off", write_reg, 0);
        chk("p_tgt_hold", target_reg, 5);

        // 3: issue then lu result through FIFO
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("s_mask_set", pending_mask, 32'h80);
        lu_valid = 1; lu_rd = 7; lu_data = 32'h1234;
        tick();
        lu_valid = 0;
        chk("s_cnt1", fifo_count, 1);
        chk("s_we0", write_reg, 0);
        chk("s_mask_hold", pending_mask, 32'h80);
        tick();
        chk("s_we", write_reg, 1);
        chk("s_tgt", target_reg, 7);
        chk("s_data", write_rd_data, 32'h1234);
        chk("s_mask_clr", pending_mask, 0);
        chk("s_cnt0", fifo_count, 0);

        // 4: fill FIFO under continuous pipe traffic, starvation stall
        for (int i = 0; i < 4; i++) begin
            pipe_valid = 1; pipe_rd = 20; pipe_data = i;
            lu_valid = 1; lu_rd = 5'(i + 1); lu_data = 32'h100 + i + 1;
            tick();
        end
        lu_valid = 0;
        chk("f_ready0", lu_ready, 0);
        chk("f_cnt4", fifo_count, 4);
        chk("f_pipe_we", target_reg, 20);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("f_nostall", pipe_stall, 0);
        end
        tick();
        chk("f_stall", pipe_stall, 1);
        pipe_valid = 0;
        tick();
        chk("f_stall_off", pipe_stall, 0);
        chk("f_h1_we", write_reg, 1);
        chk("f_h1_tgt", target_reg, 1);
        chk("f_h1_data", write_rd_data, 32'h101);
        chk("f_cnt3", fifo_count, 3);
        chk("f_ready1", lu_ready, 1);
        chk("f_perr0", proto_err, 0);

        // 5: pipe_valid during stall is dropped and flags proto_err
        pipe_valid = 1; pipe_rd = 20; pipe_data = 32'h55;
        for (int i = 0; i < 7; i++) tick();
        chk("e_nostall", pipe_stall, 0);
        tick();
        chk("e_stall", pipe_stall, 1);
        pipe_rd = 21; pipe_data = 32'hBAD;
        tick();
        pipe_valid = 0;
        chk("e_tgt2", target_reg, 2);
        chk("e_data2", write_rd_data, 32'h102);
        chk("e_perr", proto_err, 1);
        tick();
        chk("e_tgt3", target_reg, 3);
        tick();
        chk("e_tgt4", target_reg, 4);
        chk("e_data4", write_rd_data, 32'h104);
        chk("e_cnt0", fifo_count, 0);
        tick();
        chk("e_idle", write_reg, 0);
        chk("e_perr_sticky", proto_err, 1);

        // 6: set wins over same-cycle clear; rd=0 pipe leaves slot free; rd=0 entry
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_valid = 0;
        lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
        tick();
        lu_valid = 0;
        chk("w_mask3", pending_mask, 32'h8);
        issue_valid = 1; issue_rd = 3;
        tick();
        issue_valid = 0;
        chk("w_tgt3", target_reg, 3);
        chk("w_data3", write_rd_data, 32'h33);
        chk("w_mask_keep", pending_mask, 32'h8);
        issue_valid = 1; issue_rd = 6;
        lu_valid = 1; lu_rd = 6; lu_data = 32'h66;
        tick();
        issue_valid = 0; lu_valid = 0;
        chk("z_mask6", pending_mask, 32'h48);
        pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFF;
        tick();
        pipe_valid = 0;
        chk("z_we", write_reg, 1);
        chk("z_tgt6", target_reg, 6);
        chk("z_data6", write_rd_data, 32'h66);
        chk("z_mask_clr", pending_mask, 32'h8);
        lu_valid = 1; lu_rd = 0; lu_data = 32'h77;
        tick();
        lu_valid = 0;
        chk("z_cnt_rd0", fifo_count, 1);
        tick();
        chk("z_rd0_we", write_reg, 0);
        chk("z_rd0_tgt", target_reg, 6);
        chk("z_rd0_cnt", fifo_count, 0);

        // reset mid-operation discards FIFO and pending bits
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        issue_valid = 1; issue_rd = 9;
        tick();
        lu_valid = 0; issue_valid = 0;
        chk("r_cnt_pre", fifo_count, 1);
        rst = 0;
        tick();
        rst = 1;
        chk("r_cnt", fifo_count, 0);
        chk("r_mask", pending_mask, 0);
        chk("r_perr", proto_err, 0);
        tick();
        chk("r_we", write_reg, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
